// File: rtl/tt_um_irrationalanalysis_prbs31_checker.sv
// Byte-parallel PRBS31 (x^31 + x^28 + 1) checker for the Tiny Tapeout frame.
// Self-synchronises on received data, locks after clean bytes, counts bit errors while locked.
module tt_um_irrationalanalysis_prbs31_checker #(
  parameter int LOCK_BYTES = 4,
  parameter int LOL_BYTES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_e;

  localparam logic [4:0] LOCK_N = 5'(LOCK_BYTES);
  localparam logic [4:0] LOL_N  = 5'(LOL_BYTES);

  // valid has no backpressure: a byte on ui_in is consumed on every rising edge where valid is high.
  logic valid, clr, sel;
  assign valid = uio_in[0];
  assign clr   = uio_in[1];
  assign sel   = uio_in[2];

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  state_e      state_q, state_d;
  logic [30:0] h_q, h_d;
  logic [2:0]  fill_q, fill_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        lock_q, lock_d;
  logic        err_pulse_q, err_pulse_d;

  logic [7:0]  pred;
  logic [7:0]  err_vec;
  logic [3:0]  err_bits;
  logic [16:0] err_sum;
  logic [4:0]  good_inc, bad_inc;

  // h_q[0] is the most recent bit; ui_in[7] is the earliest incoming bit.
  always_comb begin
    pred     = 8'd0;
    err_bits = 4'd0;
    for (int k = 0; k < 8; k++) begin
      pred[7-k] = h_q[30-k] ^ h_q[27-k];
    end
    err_vec = pred ^ ui_in;
    for (int k = 0; k < 8; k++) begin
      err_bits = err_bits + {3'b000, err_vec[k]};
    end
    err_sum  = {1'b0, err_cnt_q} + {13'd0, err_bits};
    good_inc = {1'b0, good_q} + 5'd1;
    bad_inc  = {1'b0, bad_q} + 5'd1;
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (valid) begin
      // History always takes the received byte, never the prediction.
      h_d = {h_q[22:0], ui_in};
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
      if (state_q == ST_LOCKED) begin
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (err_vec != 8'd0) begin
          err_pulse_d = 1'b1;
          bad_d       = bad_inc[3:0];
          if (bad_inc == LOL_N) begin
            state_d = ST_HUNT;
            good_d  = 4'd0;
          end
        end else begin
          bad_d = 4'd0;
        end
      end else if (fill_q == 3'd4) begin
        // An all-zero history predicts zeros forever, so it never counts as good.
        if (err_vec == 8'd0 && h_q != 31'd0) begin
          good_d = good_inc[3:0];
          if (good_inc == LOCK_N) begin
            state_d = ST_LOCKED;
            bad_d   = 4'd0;
          end
        end else begin
          good_d = 4'd0;
        end
      end
    end
    if (clr) begin
      err_cnt_d = 16'd0;
    end
    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      h_q         <= 31'd0;
      fill_q      <= 3'd0;
      good_q      <= 4'd0;
      bad_q       <= 4'd0;
      err_cnt_q   <= 16'd0;
      lock_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_cnt_q   <= err_cnt_d;
      lock_q      <= lock_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign uo_out  = sel ? err_cnt_q[15:8] : err_cnt_q[7:0];
  assign uio_out = {lock_q, err_pulse_q, 6'b000000};
  assign uio_oe  = 8'hC0;
endmodule
